ca_row_writer: RTL and testbench
================================

// Module: ca_row_writer
// PURPOSE
//  1-D elementary cellular-automaton engine feeding port A of the dual-port VGA bit buffer.
//  - Holds one WIDTH-cell generation.
//  - Writes it one cell per clock into the buffer.
//  - Computes the next generation from an 8-bit Wolfram rule.
//  - Repeats for HEIGHT rows, filling one full frame.
//  The VGA refresh path reads the same buffer independently on port B.
// PARAMETERS
//  WIDTH   640  cells per row; must be >= 3
//  HEIGHT  480  rows per frame
//  ADDR_W  19   buffer address width; WIDTH*HEIGHT must be <= 2**ADDR_W
// PORTS
//  iCLK    in   1       system clock; all logic on posedge
//  iRST_N  in   1       asynchronous, active-low reset
//  iStart  in   1       generation request, level; rising edge detected internally
//  iRule   in   8       Wolfram rule number; sampled on accepted start
//  oAddr   out  ADDR_W  buffer port-A address
//  oData   out  1       cell value to write
//  oWe     out  1       buffer port-A write enable
//  oRow    out  9       row currently being written
//  oBusy   out  1       high from accepted start until the frame completes
//  oDone   out  1       high (level) after a complete frame until the next accepted start
// BEHAVIOUR
//  - Reset (async): state=IDLE; oAddr=0, oData=0, oWe=0, oRow=0, oBusy=0, oDone=0;
//    row register cleared; start edge register cleared.
//  - Start edge: start_q <= iStart; accepted when iStart & ~start_q in IDLE or DONE.
//    Edges in INIT/WRITE/GEN are ignored.
//  - On acceptance: rule latched; oAddr=0; oRow=0; oDone=0; oBusy=1; enter INIT.
//  - States:
//    - IDLE/DONE: oWe=0.
//    - INIT: load seed row (see CONFIGURATION) -> WRITE.
//    - WRITE: one cell per clock.
//      - Col counter x runs 0..WIDTH-1; oWe=1, oData=row[x].
//      - oAddr = oRow*WIDTH + x; implemented as an incrementing counter, no multiplier.
//      - oAddr increments after each write; x==WIDTH-1 -> GEN.
//    - GEN: one cycle, oWe=0. All cells updated in parallel:
//      - new[i] = rule[{c[i-1], c[i], c[i+1]}]
//      - c[-1] = c[WIDTH-1] and c[WIDTH] = c[0] (toroidal wrap).
//      - If oRow==HEIGHT-1 -> DONE (oBusy=0, oDone=1, oWe=0); else oRow++ -> WRITE.
//  - Rule index bit 2 is the left neighbour (i-1); cell i is written at address base+i.
//  - oAddr/oData/oWe are registered and change together on one edge; the buffer
//    captures them on the following edge.
//  - Frame time, centre seed: 1 + HEIGHT*(WIDTH+1) cycles; default 307681.
//  - iRule changes while busy: no effect until the next accepted start.
//  - Reset mid-frame: immediate abort to IDLE; partially written rows stay in the buffer.
// CONFIGURATION
//  CA_LFSR_SEED_EN
//    Defined:
//    - 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, reset value 32'h1,
//      steps every clock in every state.
//    - INIT lasts WIDTH cycles, shifting LFSR bit 0 into the row from the MSB end.
//    - Frame time grows by WIDTH-1 cycles.
//    Undefined:
//    - No LFSR is instantiated; INIT lasts 1 cycle.
//    - Seed is a single 1 at cell WIDTH/2, all other cells 0.
// TESTING
//  1. Defaults, centre seed, iRule=8'd90, start edge:
//     - Row 0: only addr 320 written 1.
//     - Row 1: addrs 959 and 961 written 1.
//     - oDone rises exactly 307681 cycles after the accepted start edge.
//  2. iRule=8'd0:
//     - Row 0 has only addr 320 set.
//     - Every write for rows 1..479 has oData=0.
//     - Last write is at addr 307199.
//  3. Wrap: WIDTH=8, HEIGHT=8, iRule=8'd170, centre seed:
//     - Set cell per row is 4,3,2,1,0,7,6,5.
//  4. Second start edge at cycle 1000 of a frame:
//     - Ignored; the address sequence is unbroken.
//     - A new edge after oDone restarts the frame at addr 0.
//  5. iRST_N low at mid-row 100:
//     - oWe=0 and oBusy=0 in the same cycle, without waiting for a clock.
//     - After release, all outputs hold reset values until the next start edge.
//  6. CA_LFSR_SEED_EN defined:
//     - Row 0 bits match the reference LFSR model.
//     - First write occurs WIDTH cycles after start; frame time is 308320.

Source files
------------

// File: rtl/ca_row_writer_if.sv
// rtl/ca_row_writer_if.sv - control and buffer port-A bundle for the CA row writer
interface ca_row_writer_if #(
  parameter int ADDR_W = 19
);
  logic              iStart;
  logic [7:0]        iRule;
  logic [ADDR_W-1:0] oAddr;
  logic              oData;
  logic              oWe;
  logic [8:0]        oRow;
  logic              oBusy;
  logic              oDone;

  // Engine side: takes start/rule, drives the buffer write port and status
  modport master (
    input  iStart, iRule,
    output oAddr, oData, oWe, oRow, oBusy, oDone
  );

  // Controller/buffer side
  modport slave (
    output iStart, iRule,
    input  oAddr, oData, oWe, oRow, oBusy, oDone
  );
endinterface

// File: rtl/ca_row_writer.sv
// rtl/ca_row_writer.sv - elementary CA engine writing WIDTHxHEIGHT frames into port A; optional CA_LFSR_SEED_EN random seed
module ca_row_writer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  ca_row_writer_if.master bus
);

  localparam int XW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] CENTRE_SEED = {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH / 2);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WRITE, S_GEN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              start_q;
  logic [7:0]        rule_q, rule_d;
  logic [WIDTH-1:0]  row_q, row_d;
  logic [WIDTH-1:0]  gen_row;
  logic [XW-1:0]     x_q, x_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              data_q, data_d;
  logic              we_q, we_d;
  logic [8:0]        rowcnt_q, rowcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              last_x;

`ifdef CA_LFSR_SEED_EN
  logic [31:0]       lfsr_q, lfsr_d;

  // Fibonacci LFSR x^32+x^22+x^2+x+1, free-running in every state
  always_comb begin
    lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  end

  // LFSR register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) lfsr_q <= 32'h1;
    else         lfsr_q <= lfsr_d;
  end
`endif

  // Next generation: every cell looks at its toroidal neighbours, left neighbour is index bit 2
  always_comb begin
    gen_row = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gen_row[i] = rule_q[{row_q[(i + WIDTH - 1) % WIDTH], row_q[i], row_q[(i + 1) % WIDTH]}];
    end
  end

  // Sequencer: start acceptance, seed load, cell writes, generation step
  always_comb begin
    state_d  = state_q;
    rule_d   = rule_q;
    row_d    = row_q;
    x_d      = x_q;
    addr_d   = addr_q;
    rowcnt_d = rowcnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    accept   = bus.iStart & ~start_q;
    last_x   = (x_q == XW'(WIDTH - 1));
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          rule_d   = bus.iRule;
          addr_d   = '0;
          rowcnt_d = '0;
          x_d      = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
`ifdef CA_LFSR_SEED_EN
        row_d = {lfsr_q[0], row_q[WIDTH-1:1]};
        if (last_x) begin
          x_d     = '0;
          state_d = S_WRITE;
        end else begin
          x_d = x_q + XW'(1);
        end
`else
        row_d   = CENTRE_SEED;
        x_d     = '0;
        state_d = S_WRITE;
`endif
      end
      S_WRITE: begin
        // The address counter walks the whole frame, so no row*WIDTH product is needed
        addr_d = addr_q + ADDR_W'(1);
        if (last_x) state_d = S_GEN;
        else        x_d = x_q + XW'(1);
      end
      S_GEN: begin
        row_d = gen_row;
        x_d   = '0;
        if (rowcnt_q == 9'(HEIGHT - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          rowcnt_d = rowcnt_q + 9'd1;
          state_d  = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Write strobe and data are registered alongside the address for the state being entered
    we_d   = (state_d == S_WRITE);
    data_d = we_d ? row_d[x_d] : 1'b0;
  end

  // State and output registers; reset aborts immediately
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      rule_q   <= '0;
      row_q    <= '0;
      x_q      <= '0;
      addr_q   <= '0;
      data_q   <= 1'b0;
      we_q     <= 1'b0;
      rowcnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.iStart;
      rule_q   <= rule_d;
      row_q    <= row_d;
      x_q      <= x_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      rowcnt_q <= rowcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.oAddr = addr_q;
  assign bus.oData = data_q;
  assign bus.oWe   = we_q;
  assign bus.oRow  = rowcnt_q;
  assign bus.oBusy = busy_q;
  assign bus.oDone = done_q;

endmodule

// File: tb/tb_ca_row_writer.sv
// tb/tb_ca_row_writer.sv - randomized self-checking bench for ca_row_writer against a generation-level model
module tb_ca_row_writer;
  localparam int W  = 11;
  localparam int H  = 9;
  localparam int AW = 7;
  localparam int FRAME_LAT = 1 + H * (W + 1);

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   exp_cells [H][W];

  always #5 clk = ~clk;

  ca_row_writer_if #(.ADDR_W(AW)) bus ();

  ca_row_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: whole generations computed from the rule table with toroidal neighbours
  function automatic void build_model(input logic [7:0] rule);
    for (int x = 0; x < W; x++) exp_cells[0][x] = (x == W / 2);
    for (int r = 1; r < H; r++) begin
      for (int i = 0; i < W; i++) begin
        int l, c, rr;
        l  = exp_cells[r-1][(i + W - 1) % W];
        c  = exp_cells[r-1][i];
        rr = exp_cells[r-1][(i + 1) % W];
        exp_cells[r][i] = rule[l * 4 + c * 2 + rr];
      end
    end
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},   32'(bus.oWe),   0);
    check({tag, "_busy"}, 32'(bus.oBusy), 0);
    check({tag, "_done"}, 32'(bus.oDone), 0);
    check({tag, "_addr"}, 32'(bus.oAddr), 0);
    check({tag, "_row"},  32'(bus.oRow),  0);
    check({tag, "_data"}, 32'(bus.oData), 0);
  endtask

  // One frame; optionally a spurious start edge mid-frame, or a reset at a given cycle
  task automatic run_frame(input logic [7:0] rule, input int glitch_at, input int abort_at);
    int  n;
    int  wi;
    bit  done_seen;
    build_model(rule);
    @(negedge clk);
    bus.iRule  = rule;
    bus.iStart = 1'b1;
    n = 0;
    wi = 0;
    done_seen = 1'b0;
    while (!done_seen && n < FRAME_LAT + 50) begin
      @(negedge clk);
      n++;
      bus.iRule = 8'($urandom);
      if (n == glitch_at)     bus.iStart = 1'b0;
      if (n == glitch_at + 3) bus.iStart = 1'b1;
      if (n == 1) begin
        check("busy_after_start", 32'(bus.oBusy), 1);
        check("done_cleared",     32'(bus.oDone), 0);
      end
      if (abort_at > 0 && n == abort_at) begin
        check("we_before_abort", 32'(bus.oWe), 1);
        bus.iStart = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_we",   32'(bus.oWe),   0);
        check("abort_busy", 32'(bus.oBusy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check_idle_outputs("post_reset");
        end
        return;
      end
      if (bus.oWe) begin
        if (wi == 0) check("first_write_cycle", n, 2);
        if (wi < W * H) begin
          check("addr", 32'(bus.oAddr), wi);
          check("data", 32'(bus.oData), 32'(exp_cells[wi / W][wi % W]));
          check("row",  32'(bus.oRow),  wi / W);
        end else begin
          check("extra_write", wi, W * H - 1);
        end
        wi++;
      end
      if (bus.oDone) begin
        done_seen = 1'b1;
        check("done_latency", n - 1, FRAME_LAT);
      end
    end
    if (!done_seen) check("done_timeout", 0, 1);
    check("write_count", wi, W * H);
    check("busy_at_done", 32'(bus.oBusy), 0);
    bus.iStart = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("done_held", 32'(bus.oDone), 1);
      check("idle_we",   32'(bus.oWe),   0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.iStart = 1'b0;
    bus.iRule  = 8'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("after_release");

    run_frame(8'd90, 30, 0);
    run_frame(8'd0, -10, 0);
    run_frame(8'd170, -10, 0);
    run_frame(8'd30, 45, 0);
    run_frame(8'd110, -10, 2 + 4 * (W + 1) + 5);
    run_frame(8'd90, -10, 0);
    for (int t = 0; t < 4; t++) begin
      run_frame(8'($urandom), (t % 2 == 0) ? 20 + int'($urandom_range(0, 60)) : -10, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
